micro_uart_apb_master: RTL and testbench
========================================

# micro_uart_apb_master

Serial-to-APB debug bridge: consumes a byte stream from a micro UART receiver, decodes read/write command frames, and drives them as an APB initiator onto the peripheral bus. Responses (status and read data) are returned as a byte stream to a micro UART transmitter. It is the initiator-side counterpart of the micro UART APB slave wrappers, giving a host PC bus access without a CPU.

## Interface
- ADDR_BYTES, 2, address bytes per frame; apb_paddr width is 8*ADDR_BYTES
- TIMEOUT, 255, APB access-phase cycle limit (used only with timeout compiled in)

- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
- apb_psel  out  1  APB select
- apb_penable  out  1  APB enable
- apb_pwrite  out  1  APB write
- apb_paddr  out  8*ADDR_BYTES  APB address
- apb_pwdata  out  32  APB write data
- apb_prdata  in  32  APB read data
- apb_pready  in  1  APB ready
- apb_pslverr  in  1  APB error
- busy  out  1  high in every state except IDLE

## Operation
- Frame: command byte, then ADDR_BYTES address bytes MSB first, then (write only) 4 data bytes MSB first.
- Commands: 0x57 write, 0x52 read; any other byte in IDLE is discarded.
- States: IDLE -> ADDR (on valid command) -> DATA (write) or SETUP (read, after last address byte); DATA -> SETUP after 4th byte; SETUP -> ACCESS; ACCESS -> RESP on apb_pready; RESP -> IDLE when last response byte handshakes.
- Byte counter counts received bytes within ADDR/DATA, cleared on state entry.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata stable. ACCESS: psel=1, penable=1, held until pready=1; prdata and pslverr sampled on that cycle.
- Response: status byte 0x4B ('K') OK, 0x45 ('E') pslverr, 0x54 ('T') timeout. Write: status only. Read: status then 4 bytes of captured prdata MSB first (zeros on timeout); always 5 bytes.
- rx_valid in SETUP/ACCESS/RESP: byte dropped, no effect.
- apb_pwdata driven 0 for reads; paddr/pwrite/pwdata hold last values in IDLE.

## Timing
- Reset: psel, penable, pwrite, paddr, pwdata, tx_valid, tx_data, busy all 0; state IDLE. Asserting reset_n low mid-transfer drops psel/penable immediately (asynchronous).
- Last frame byte on cycle N -> SETUP on N+1 -> ACCESS on N+2; zero-wait slave completes on N+2.
- Status byte tx_valid high the cycle after pready; each subsequent response byte presented the cycle after the previous handshake.
- tx_data/tx_valid must not change while tx_valid & !tx_ready.
- psel and penable deasserted the cycle after pready (no back-to-back transfers).

## Configuration
- MICRO_UART_APBM_TIMEOUT_EN defined: ACCESS cycle counter; if pready not seen after TIMEOUT access cycles, psel/penable drop next cycle, status 0x54 returned.
- Not defined: no counter; ACCESS waits indefinitely for pready; TIMEOUT ignored; 0x54 never produced.

## Structure
- Package micro_uart_apbm_pkg: command constants (0x57, 0x52), status constants (0x4B, 0x45, 0x54), state enum.
- Sub-module micro_uart_apbm_txser: loads status + 32-bit data + length, serializes with tx_valid/tx_ready handshake, flags done.

## Test plan
- Write frame 57 00 10 DE AD BE EF, zero-wait slave -> paddr=0x0010, pwdata=0xDEADBEEF, pwrite=1, SETUP then ACCESS one cycle each; tx 0x4B.
- Read frame 52 00 04, slave pready after 3 wait cycles with prdata=0x12345678 -> tx 4B 12 34 56 78, penable held 4 cycles.
- Read with pslverr=1, prdata=0xCAFEF00D -> tx 45 CA FE F0 0D.
- Junk bytes 0x00, 0xFF before command, plus rx bytes during ACCESS -> ignored; frame executes correctly.
- tx_ready held low 10 cycles during response -> tx_data/tx_valid stable, no byte lost.
- With MICRO_UART_APBM_TIMEOUT_EN, TIMEOUT=8, pready never asserted -> psel drops after 8 access cycles, tx 54 00 00 00 00 (read); reset_n pulsed mid-ACCESS -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/micro_uart_apbm_pkg.sv
// Shared constants and state encoding for the UART-to-APB debug bridge.
package micro_uart_apbm_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  localparam logic [7:0] STS_OK  = 8'h4B;
  localparam logic [7:0] STS_ERR = 8'h45;
  localparam logic [7:0] STS_TMO = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/micro_uart_apbm_txser.sv
// Response serializer: loads status + 32-bit data + byte count, emits bytes MSB first
// over a valid/ready handshake and pulses done on the last accepted byte.
module micro_uart_apbm_txser
  import micro_uart_apbm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [7:0]  status,
  input  logic [31:0] data,
  input  logic [2:0]  len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [39:0] buf_d, buf_q;
  logic [2:0]  rem_d, rem_q;
  logic        valid_d, valid_q;

  always_comb begin
    buf_d   = buf_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    if (load) begin
      buf_d   = {status, data};
      rem_d   = len;
      valid_d = 1'b1;
    end else if (valid_q && tx_ready) begin
      buf_d   = {buf_q[31:0], 8'h00};
      rem_d   = rem_q - 3'd1;
      valid_d = (rem_q != 3'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data  = buf_q[39:32];
  assign tx_valid = valid_q;
  assign done     = valid_q && tx_ready && (rem_q == 3'd1);

endmodule

// File: rtl/micro_uart_apb_master.sv
// UART byte stream to APB initiator bridge with status/read-data response.
// Optional access timeout compiled in with MICRO_UART_APBM_TIMEOUT_EN.
module micro_uart_apb_master
  import micro_uart_apbm_pkg::*;
#(
  parameter int ADDR_BYTES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    apb_psel,
  output logic                    apb_penable,
  output logic                    apb_pwrite,
  output logic [8*ADDR_BYTES-1:0] apb_paddr,
  output logic [31:0]             apb_pwdata,
  input  logic [31:0]             apb_prdata,
  input  logic                    apb_pready,
  input  logic                    apb_pslverr,
  output logic                    busy
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam logic [3:0] ADDR_LAST = 4'(ADDR_BYTES - 1);

  state_e          state_d, state_q;
  logic [3:0]      cnt_d, cnt_q;
  logic            pwrite_d, pwrite_q;
  logic [AW-1:0]   paddr_d, paddr_q;
  logic [31:0]     pwdata_d, pwdata_q;
  logic            load;
  logic [7:0]      status;
  logic [31:0]     rdata;
  logic [2:0]      len;
  logic            done;
`ifdef MICRO_UART_APBM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]     tmo_d, tmo_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    load     = 1'b0;
    status   = STS_OK;
    rdata    = '0;
    len      = pwrite_q ? 3'd1 : 3'd5;
`ifdef MICRO_UART_APBM_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          state_d  = ST_ADDR;
          cnt_d    = '0;
          pwrite_d = (rx_data == CMD_WRITE);
          if (rx_data == CMD_READ) pwdata_d = '0;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          paddr_d = AW'({paddr_q, rx_data});
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = pwrite_q ? ST_DATA : ST_SETUP;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          pwdata_d = {pwdata_q[23:0], rx_data};
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            cnt_d   = '0;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef MICRO_UART_APBM_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_ACCESS: begin
        // The response is loaded on the completing edge so the status byte
        // appears in the very next cycle.
        if (apb_pready) begin
          load    = 1'b1;
          status  = apb_pslverr ? STS_ERR : STS_OK;
          rdata   = pwrite_q ? 32'h0 : apb_prdata;
          state_d = ST_RESP;
        end
`ifdef MICRO_UART_APBM_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          load    = 1'b1;
          status  = STS_TMO;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      ST_RESP: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
`ifdef MICRO_UART_APBM_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
`ifdef MICRO_UART_APBM_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  micro_uart_apbm_txser u_txser (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .status   (status),
    .data     (rdata),
    .len      (len),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (done)
  );

  assign apb_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign apb_penable = (state_q == ST_ACCESS);
  assign apb_pwrite  = pwrite_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_micro_uart_apb_master.sv
// Self-checking bench for micro_uart_apb_master: directed and random frames against
// a byte-level reference model of the response stream and APB phase timing.
module tb_micro_uart_apb_master;

`ifdef MICRO_UART_APBM_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [15:0] apb_paddr;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata = 32'h0;
  logic        apb_pready = 1'b0;
  logic        apb_pslverr = 1'b0;
  logic        busy;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  micro_uart_apb_master #(.ADDR_BYTES(2), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_paddr   (apb_paddr),
    .apb_pwdata  (apb_pwdata),
    .apb_prdata  (apb_prdata),
    .apb_pready  (apb_pready),
    .apb_pslverr (apb_pslverr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      rx_data = 8'($urandom);
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // wait_n < 0 means the slave never answers
  task automatic do_frame(input bit is_wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input int wait_n, input logic [31:0] rdata, input bit err,
                          input int stall, input bit noise);
    logic [7:0] frame[$];
    logic [7:0] exp_q[$];
    logic [7:0] sts;
    int acc, exp_acc, stall_idx;
    bit tmo;
    frame.push_back(is_wr ? 8'h57 : 8'h52);
    frame.push_back(addr[15:8]);
    frame.push_back(addr[7:0]);
    if (is_wr) for (int i = 3; i >= 0; i--) frame.push_back(8'(wdata >> (8 * i)));
    foreach (frame[i]) send_byte(frame[i]);

    check("setup_psel", apb_psel, 1);
    check("setup_penable", apb_penable, 0);
    check("setup_paddr", apb_paddr, addr);
    check("setup_pwrite", apb_pwrite, is_wr);
    check("setup_pwdata", apb_pwdata, is_wr ? wdata : 32'h0);
    if (noise) begin
      rx_data  = 8'h57;
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;

    acc = 0;
    while (apb_penable && acc < TIMEOUT + 2) begin
      acc++;
      check("access_psel", apb_psel, 1);
      if (noise) begin
        rx_data  = 8'h52;
        rx_valid = 1'b1;
      end
      if (wait_n >= 0 && acc == wait_n + 1) begin
        apb_pready  = 1'b1;
        apb_prdata  = rdata;
        apb_pslverr = err;
      end
      @(negedge clk);
      rx_valid    = 1'b0;
      apb_pready  = 1'b0;
      apb_prdata  = $urandom;
      apb_pslverr = 1'($urandom);
    end
    tmo     = (wait_n < 0);
    exp_acc = tmo ? TIMEOUT : wait_n + 1;
    check("access_cycles", acc, exp_acc);
    check("resp_psel", apb_psel, 0);
    check("resp_penable", apb_penable, 0);

    sts = tmo ? 8'h54 : (err ? 8'h45 : 8'h4B);
    exp_q.push_back(sts);
    if (!is_wr) for (int i = 3; i >= 0; i--) exp_q.push_back(tmo ? 8'h00 : 8'(rdata >> (8 * i)));
    stall_idx = exp_q.size() / 2;
    foreach (exp_q[i]) begin
      check("tx_valid", tx_valid, 1);
      check("tx_data", tx_data, exp_q[i]);
      if (i == stall_idx) begin
        repeat (stall) begin
          @(negedge clk);
          check("stall_valid", tx_valid, 1);
          check("stall_data", tx_data, exp_q[i]);
        end
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
    check("end_tx_valid", tx_valid, 0);
    check("end_busy", busy, 0);
  endtask

  initial begin
    $display("[TB] start, TIMEOUT=%0d", TIMEOUT);
    repeat (3) @(negedge clk);
    check("rst_psel", apb_psel, 0);
    check("rst_penable", apb_penable, 0);
    check("rst_pwrite", apb_pwrite, 0);
    check("rst_paddr", apb_paddr, 0);
    check("rst_pwdata", apb_pwdata, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed write, zero-wait");
    do_frame(1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0, 1'b0);
    $display("[TB] directed read, 3 wait states");
    do_frame(1'b0, 16'h0004, 32'h0, 3, 32'h12345678, 1'b0, 0, 1'b0);
    $display("[TB] read with slave error");
    do_frame(1'b0, 16'h0008, 32'h0, 1, 32'hCAFEF00D, 1'b1, 0, 1'b0);

    $display("[TB] junk bytes then write with rx noise");
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_busy", busy, 0);
    do_frame(1'b1, 16'hA5C3, 32'h01020304, 2, 32'h0, 1'b0, 0, 1'b1);

    $display("[TB] read with 10-cycle tx stall");
    do_frame(1'b0, 16'h0100, 32'h0, 0, 32'hA1B2C3D4, 1'b0, 10, 1'b0);
    repeat (2) @(negedge clk);
    check("idle_hold_paddr", apb_paddr, 16'h0100);
    check("idle_hold_pwrite", apb_pwrite, 0);
    check("idle_hold_pwdata", apb_pwdata, 0);

    $display("[TB] random frames");
    for (int n = 0; n < 10; n++) begin
      do_frame(1'($urandom), 16'($urandom), $urandom, int'($urandom_range(0, 4)), $urandom,
               1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] reset mid-ACCESS");
    send_byte(8'h52);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    check("pre_rst_penable", apb_penable, 1);
    reset_n = 1'b0;
    #1;
    check("arst_psel", apb_psel, 0);
    check("arst_penable", apb_penable, 0);
    check("arst_busy", busy, 0);
    check("arst_tx_valid", tx_valid, 0);
    check("arst_paddr", apb_paddr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    do_frame(1'b0, 16'h0044, 32'h0, 1, 32'h0BADF00D, 1'b0, 1, 1'b0);

`ifdef MICRO_UART_APBM_TIMEOUT_EN
    $display("[TB] timeout read");
    do_frame(1'b0, 16'h0020, 32'h0, -1, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
